ahb_lite_master_if: RTL and testbench

Single-outstanding AHB master that converts the RISC-V core's load/store requests into AHB transfers for the AHB-APB UART bridge and other AHB slaves. It sits directly upstream of the bridge. It drives HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA and consumes HRDATA/HREADY/HRESP. It handles wait states, two-cycle ERROR/RETRY/SPLIT responses, lane steering and request legality checks.

---
 rtl/ahb_lite_master_if.sv | 197 +++++++++++++++++++
 tb/tb_ahb_lite_master_if.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master_if.sv
// Single-outstanding AHB-Lite master: turns core load/store requests into SINGLE transfers.
// Optional bus watchdog is compiled in with `define AHB_TIMEOUT_EN.
module ahb_lite_master_if #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [1:0]  cpu_size_i,
  output logic        cpu_gnt_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_err_o,
  output logic        cpu_busy_o,
  output logic        timeout_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_ERROR   = 2'b01;
  localparam int RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP2} state_t;

  state_t         state_reg;
  logic [31:0]    addr_reg;
  logic [31:0]    wdata_reg;
  logic [31:0]    hwdata_reg;
  logic [31:0]    rdata_reg;
  logic [1:0]     size_reg;
  logic [1:0]     htrans_reg;
  logic           we_reg;
  logic           rvalid_reg;
  logic           err_reg;
  logic [RCW-1:0] retry_cnt_reg;
  logic           illegal;
  logic           wait_expired;
  logic [31:0]    steered;
  logic [31:0]    load_data;

  assign illegal = (cpu_size_i == 2'b11) ||
                   ((cpu_size_i == 2'b01) && cpu_addr_i[0]) ||
                   ((cpu_size_i == 2'b10) && (cpu_addr_i[1:0] != 2'b00));

  // Narrow stores are replicated so the slave can pick its lane from HADDR.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign steered[gi*8 +: 8] = (size_reg == 2'b00) ? wdata_reg[7:0] :
                                (size_reg == 2'b01) ? wdata_reg[(gi%2)*8 +: 8] :
                                                      wdata_reg[gi*8 +: 8];
  end

  always_comb begin
    load_data = HRDATA;
    case (size_reg)
      2'b00:   load_data = {24'h0, HRDATA[{addr_reg[1:0], 3'b000} +: 8]};
      2'b01:   load_data = {16'h0, (addr_reg[1] ? HRDATA[31:16] : HRDATA[15:0])};
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      hwdata_reg    <= '0;
      rdata_reg     <= '0;
      size_reg      <= '0;
      htrans_reg    <= TRANS_IDLE;
      we_reg        <= 1'b0;
      rvalid_reg    <= 1'b0;
      err_reg       <= 1'b0;
      retry_cnt_reg <= '0;
    end else begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
      if (wait_expired) begin
        htrans_reg <= TRANS_IDLE;
        rvalid_reg <= 1'b1;
        err_reg    <= 1'b1;
        state_reg  <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cpu_req_i) begin
              retry_cnt_reg <= '0;
              if (illegal) begin
                rvalid_reg <= 1'b1;
                err_reg    <= 1'b1;
              end else begin
                addr_reg   <= cpu_addr_i;
                we_reg     <= cpu_we_i;
                wdata_reg  <= cpu_wdata_i;
                size_reg   <= cpu_size_i;
                htrans_reg <= TRANS_NONSEQ;
                state_reg  <= ADDR;
              end
            end
          end
          ADDR: begin
            if (HREADY) begin
              htrans_reg <= TRANS_IDLE;
              hwdata_reg <= steered;
              state_reg  <= DATA;
            end
          end
          DATA: begin
            if (HREADY) begin
              // A single-cycle non-OKAY response is a slave protocol error; report it.
              rvalid_reg <= 1'b1;
              state_reg  <= IDLE;
              if (HRESP == RESP_OKAY)
                rdata_reg <= we_reg ? 32'h0 : load_data;
              else
                err_reg <= 1'b1;
            end else if (HRESP != RESP_OKAY) begin
              state_reg <= RESP2;
            end
          end
          RESP2: begin
            if (HREADY) begin
              if ((HRESP != RESP_ERROR) && (HRESP != RESP_OKAY) &&
                  (retry_cnt_reg < RCW'(MAX_RETRY))) begin
                retry_cnt_reg <= retry_cnt_reg + 1'b1;
                htrans_reg    <= TRANS_NONSEQ;
                state_reg     <= ADDR;
              end else begin
                rvalid_reg <= 1'b1;
                err_reg    <= 1'b1;
                state_reg  <= IDLE;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

`ifdef AHB_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCW-1:0] wait_cnt_reg;
  logic           timeout_reg;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of a live transfer.
  assign wait_expired = (state_reg != IDLE) && !HREADY &&
                        (wait_cnt_reg == WCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= wait_expired;
      if (HREADY || (state_reg == IDLE) || wait_expired)
        wait_cnt_reg <= '0;
      else
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign timeout_o = timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wait_expired = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  assign cpu_gnt_o    = cpu_req_i && (state_reg == IDLE);
  assign cpu_busy_o   = (state_reg != IDLE);
  assign cpu_rvalid_o = rvalid_reg;
  assign cpu_rdata_o  = rdata_reg;
  assign cpu_err_o    = err_reg;
  assign HADDR        = addr_reg;
  assign HTRANS       = htrans_reg;
  assign HWRITE       = we_reg;
  assign HSIZE        = {1'b0, size_reg};
  assign HBURST       = 3'b000;
  assign HWDATA       = hwdata_reg;

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Randomized bench: builds a cycle-by-cycle plan from transaction rules, drives it, checks every cycle.
module tb_ahb_lite_master_if;
  localparam int MAX_RETRY = 4;
  localparam int TO_CYC    = 8;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic [1:0]  cpu_size_i = '0;
  logic        cpu_gnt_o, cpu_rvalid_o, cpu_err_o, cpu_busy_o, timeout_o;
  logic [31:0] cpu_rdata_o, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic [1:0]  HRESP = '0;

  ahb_lite_master_if #(.TIMEOUT_CYCLES(TO_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_size_i(cpu_size_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .cpu_err_o(cpu_err_o), .cpu_busy_o(cpu_busy_o), .timeout_o(timeout_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // One entry per clock cycle: what to drive and what the outputs must be.
  typedef struct {
    bit          chk, rstn, chk_reset, chk_ctrl, chk_wdata;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        e_gnt, e_busy, e_rvalid, e_err, e_timeout, e_hwrite;
    logic [1:0]  e_htrans;
    logic [31:0] e_rdata, e_haddr, e_hwdata;
    logic [2:0]  e_hsize;
  } cyc_t;

  cyc_t        plan[$];
  int          checks = 0;
  int          errors = 0;
  logic        pend_v = 1'b0, pend_e = 1'b0, pend_to = 1'b0;
  logic [31:0] pend_d = '0;
  int          txn_cnt = 0;

  function automatic logic [31:0] steer(logic [31:0] d, logic [1:0] size);
    case (size)
      2'b00:   return {24'h0, d[7:0]} * 32'h0101_0101;
      2'b01:   return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract(logic [31:0] r, logic [31:0] a, logic [1:0] size);
    logic [31:0] sh;
    sh = r >> (8 * a[1:0]);
    case (size)
      2'b00:   return sh & 32'h0000_00FF;
      2'b01:   return sh & 32'h0000_FFFF;
      default: return r;
    endcase
  endfunction

  function automatic bit is_illegal(logic [31:0] a, logic [1:0] size);
    return (size == 2'b11) || (size == 2'b01 && (a % 2) != 0) || (size == 2'b10 && (a % 4) != 0);
  endfunction

  function automatic cyc_t new_cyc();
    cyc_t c;
    c = '{default: 0};
    c.chk = 1'b1;
    c.rstn = 1'b1;
    c.hrdata = $urandom;
    c.hready = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // Busy cycles carry junk requests that must be ignored.
  function automatic cyc_t busy_cyc();
    cyc_t c;
    c = new_cyc();
    c.e_busy = 1'b1;
    c.req = 1'($urandom_range(0, 1));
    c.we = 1'($urandom_range(0, 1));
    c.addr = $urandom;
    c.wdata = $urandom;
    c.size = 2'($urandom_range(0, 3));
    return c;
  endfunction

  function automatic void push(cyc_t c);
    c.e_rvalid = pend_v;
    c.e_err = pend_e;
    c.e_rdata = pend_d;
    c.e_timeout = pend_to;
    pend_v = 1'b0; pend_e = 1'b0; pend_d = '0; pend_to = 1'b0;
    plan.push_back(c);
  endfunction

  function automatic void add_idle(int n);
    for (int i = 0; i < n; i++) push(new_cyc());
  endfunction

  // nret RETRY/SPLIT responses, then OKAY or ERROR (unless retries are exhausted).
  // aw/dw < 0 pick random wait states per attempt.
  function automatic void add_txn(logic we, logic [31:0] addr, logic [31:0] wdata, logic [1:0] size,
                                  int nret, bit fin_err, int aw_f, int dw_f,
                                  bit fix_hrd, logic [31:0] hrd);
    cyc_t c;
    int attempts, aw, dw;
    logic [1:0] resp;
    c = new_cyc();
    c.req = 1'b1; c.we = we; c.addr = addr; c.wdata = wdata; c.size = size; c.e_gnt = 1'b1;
    push(c);
    if (is_illegal(addr, size)) begin
      pend_v = 1'b1; pend_e = 1'b1; pend_d = '0;
      return;
    end
    attempts = (nret > MAX_RETRY) ? MAX_RETRY + 1 : nret + 1;
    for (int a = 0; a < attempts; a++) begin
      aw = (aw_f < 0) ? int'($urandom_range(0, 2)) : aw_f;
      dw = (dw_f < 0) ? int'($urandom_range(0, 3)) : dw_f;
      if (a < nret) resp = 2'($urandom_range(2, 3));
      else          resp = fin_err ? 2'b01 : 2'b00;
      for (int i = 0; i <= aw; i++) begin
        c = busy_cyc();
        c.hready = (i == aw); c.hresp = 2'b00; c.e_htrans = 2'b10; c.chk_ctrl = 1'b1;
        c.e_haddr = addr; c.e_hwrite = we; c.e_hsize = {1'b0, size};
        push(c);
      end
      for (int i = 0; i < dw; i++) begin
        c = busy_cyc();
        c.hready = 1'b0; c.hresp = 2'b00; c.chk_wdata = we; c.e_hwdata = steer(wdata, size);
        push(c);
      end
      if (resp == 2'b00) begin
        c = busy_cyc();
        c.hready = 1'b1; c.hresp = 2'b00; c.chk_wdata = we; c.e_hwdata = steer(wdata, size);
        if (fix_hrd) c.hrdata = hrd;
        push(c);
        pend_v = 1'b1; pend_e = 1'b0; pend_d = we ? 32'h0 : extract(c.hrdata, addr, size);
      end else begin
        c = busy_cyc();
        c.hready = 1'b0; c.hresp = resp; c.chk_wdata = we; c.e_hwdata = steer(wdata, size);
        push(c);
        c = busy_cyc();
        c.hready = 1'b1; c.hresp = resp; c.chk_wdata = we; c.e_hwdata = steer(wdata, size);
        push(c);
        if (resp == 2'b01 || a == MAX_RETRY) begin
          pend_v = 1'b1; pend_e = 1'b1; pend_d = '0;
        end
      end
    end
  endfunction

  function automatic void add_reset_txn();
    cyc_t c;
    c = new_cyc();
    c.req = 1'b1; c.we = 1'b1; c.addr = 32'h4000_0010; c.wdata = 32'h1234_5678; c.size = 2'b10;
    c.e_gnt = 1'b1;
    push(c);
    c = busy_cyc();
    c.hready = 1'b1; c.hresp = 2'b00; c.e_htrans = 2'b10; c.chk_ctrl = 1'b1;
    c.e_haddr = 32'h4000_0010; c.e_hwrite = 1'b1; c.e_hsize = 3'b010;
    push(c);
    for (int i = 0; i < 3; i++) begin
      c = busy_cyc();
      c.hready = 1'b0; c.hresp = 2'b00; c.chk_wdata = 1'b1; c.e_hwdata = 32'h1234_5678;
      c.rstn = (i != 2);
      push(c);
    end
    c = new_cyc();
    c.chk_reset = 1'b1;
    push(c);
  endfunction

`ifdef AHB_TIMEOUT_EN
  function automatic void add_timeout_txn();
    cyc_t c;
    c = new_cyc();
    c.req = 1'b1; c.we = 1'b0; c.addr = 32'h3000_0000; c.size = 2'b10; c.e_gnt = 1'b1;
    push(c);
    for (int i = 0; i < TO_CYC; i++) begin
      c = busy_cyc();
      c.hready = 1'b0; c.hresp = 2'b00; c.e_htrans = 2'b10; c.chk_ctrl = 1'b1;
      c.e_haddr = 32'h3000_0000; c.e_hwrite = 1'b0; c.e_hsize = 3'b010;
      push(c);
    end
    pend_v = 1'b1; pend_e = 1'b1; pend_d = '0; pend_to = 1'b1;
  endfunction
`endif

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic compare(input int k);
    cyc_t c;
    c = plan[k];
    check("gnt",     k, 32'(cpu_gnt_o),    32'(c.e_gnt));
    check("busy",    k, 32'(cpu_busy_o),   32'(c.e_busy));
    check("htrans",  k, 32'(HTRANS),       32'(c.e_htrans));
    check("rvalid",  k, 32'(cpu_rvalid_o), 32'(c.e_rvalid));
    check("err",     k, 32'(cpu_err_o),    32'(c.e_err));
    check("rdata",   k, cpu_rdata_o,       c.e_rdata);
    check("timeout", k, 32'(timeout_o),    32'(c.e_timeout));
    check("hburst",  k, 32'(HBURST),       32'd0);
    if (c.chk_ctrl) begin
      check("haddr",  k, HADDR,        c.e_haddr);
      check("hwrite", k, 32'(HWRITE),  32'(c.e_hwrite));
      check("hsize",  k, 32'(HSIZE),   32'(c.e_hsize));
    end
    if (c.chk_wdata) check("hwdata", k, HWDATA, c.e_hwdata);
    if (c.chk_reset) begin
      check("rst_haddr",  k, HADDR,       32'h0);
      check("rst_hwrite", k, 32'(HWRITE), 32'h0);
      check("rst_hsize",  k, 32'(HSIZE),  32'h0);
      check("rst_hwdata", k, HWDATA,      32'h0);
    end
    if (cpu_rvalid_o === 1'b1) begin
      txn_cnt++;
      $display("txn %0d done cycle %0d: err=%0b rdata=%h timeout=%0b", txn_cnt, k, cpu_err_o, cpu_rdata_o, timeout_o);
    end
  endtask

  initial begin
    cyc_t c;
    int req_idx, nnonseq, nret;
    logic [1:0]  sz;
    logic [31:0] a;

    // Power-on reset, then confirm reset values.
    for (int i = 0; i < 2; i++) begin
      c = new_cyc(); c.rstn = 1'b0; c.chk = 1'b0; push(c);
    end
    c = new_cyc(); c.chk_reset = 1'b1; push(c);

    // Model pins against hand-computed values.
    check("pin_steer_byte", -1, steer(32'h0000_00AB, 2'b00), 32'hABAB_ABAB);
    check("pin_steer_half", -1, steer(32'hFFFF_1234, 2'b01), 32'h1234_1234);
    check("pin_extract_half", -1, extract(32'hA1B2_C3D4, 32'h0000_0002, 2'b01), 32'h0000_A1B2);

    req_idx = plan.size();
    add_txn(1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 2'b10, 0, 1'b0, 0, 0, 1'b0, 32'h0);
    check("pin_store_lat", -1, 32'(plan.size() - req_idx), 32'd3);
    check("pin_store_hwdata", -1, plan[req_idx + 2].e_hwdata, 32'hDEAD_BEEF);
    check("pin_store_hsize", -1, 32'(plan[req_idx + 1].e_hsize), 32'b010);
    add_idle(1);

    req_idx = plan.size();
    add_txn(1'b0, 32'h2000_0003, 32'h0, 2'b00, 0, 1'b0, 0, 2, 1'b1, 32'hA1B2_C3D4);
    check("pin_load_lat", -1, 32'(plan.size() - req_idx), 32'd5);
    check("pin_load_data", -1, pend_d, 32'h0000_00A1);
    add_idle(1);

    req_idx = plan.size();
    add_txn(1'b1, 32'h2000_0001, 32'h5555, 2'b01, 0, 1'b0, 0, 0, 1'b0, 32'h0);
    check("pin_illegal_lat", -1, 32'(plan.size() - req_idx), 32'd1);
    add_txn(1'b1, 32'h2000_0000, 32'h5555, 2'b11, 0, 1'b0, 0, 0, 1'b0, 32'h0);
    add_idle(1);

    add_txn(1'b0, 32'h5000_0004, 32'h0, 2'b10, 0, 1'b1, 0, 1, 1'b0, 32'h0);
    add_idle(1);

    req_idx = plan.size();
    add_txn(1'b0, 32'h6000_0008, 32'h0, 2'b10, MAX_RETRY + 1, 1'b0, 0, 0, 1'b0, 32'h0);
    nnonseq = 0;
    for (int i = req_idx; i < plan.size(); i++) if (plan[i].e_htrans == 2'b10) nnonseq++;
    check("pin_retry_phases", -1, 32'(nnonseq), 32'd5);
    add_idle(1);
    add_txn(1'b1, 32'h6000_000C, 32'hCAFE_F00D, 2'b10, 1, 1'b0, 0, 0, 1'b0, 32'h0);
    add_idle(1);

    add_reset_txn();
`ifdef AHB_TIMEOUT_EN
    add_timeout_txn();
    add_idle(1);
`endif

    for (int t = 0; t < 160; t++) begin
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      nret = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      add_txn(1'($urandom_range(0, 1)), a, $urandom, sz, nret, ($urandom_range(0, 4) == 0),
              -1, -1, 1'b0, 32'h0);
      add_idle(int'($urandom_range(0, 2)));
    end
    add_idle(3);

    for (int k = 0; k < plan.size(); k++) begin
      @(posedge HCLK);
      #1;
      HRESETn     = plan[k].rstn;
      cpu_req_i   = plan[k].req;
      cpu_we_i    = plan[k].we;
      cpu_addr_i  = plan[k].addr;
      cpu_wdata_i = plan[k].wdata;
      cpu_size_i  = plan[k].size;
      HREADY      = plan[k].hready;
      HRESP       = plan[k].hresp;
      HRDATA      = plan[k].hrdata;
      @(negedge HCLK);
      if (plan[k].chk) compare(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
